// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed load/store target with one outstanding transaction.
// Response appears WAIT_CYCLES edges after the accept edge; outputs held until resp_ready.
// Optional DMR_STATS_EN macro adds saturating load/store/error counters.
module data_mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              resp_we
`ifdef DMR_STATS_EN
  ,
  output logic [15:0]       stat_rd,
  output logic [15:0]       stat_wr,
  output logic [15:0]       stat_err
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_M1 = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              go_resp;
  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic              cur_err;
  logic [IDX_W-1:0]  cur_idx;

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign accept     = req_ready && req_valid;

  // With zero wait states the commit happens on the accept edge, so the
  // request fields come straight from the inputs instead of the latches.
  assign cur_we    = (state == S_IDLE) ? req_we    : lat_we;
  assign cur_addr  = (state == S_IDLE) ? req_addr  : lat_addr;
  assign cur_wdata = (state == S_IDLE) ? req_wdata : lat_wdata;
  assign cur_err   = (32'(cur_addr) >= 32'(DEPTH));
  assign cur_idx   = cur_addr[IDX_W-1:0];

  assign go_resp = (accept && (WAIT_CYCLES == 0)) || ((state == S_WAIT) && (cnt == 4'd0));

  // Control FSM, wait counter and registered response fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      resp_we    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (WAIT_CYCLES == 0) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= WAIT_M1;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (go_resp) begin
        resp_err   <= cur_err;
        resp_we    <= cur_we;
        resp_rdata <= (!cur_we && !cur_err) ? mem[cur_idx] : '0;
      end
    end
  end

  // Request capture; data path only, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we    <= req_we;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end
  end

  // Store commit on entry to RESP; out-of-range stores never touch the array.
  always_ff @(posedge clk) begin
    if (!rst && go_resp && cur_we && !cur_err) begin
      mem[cur_idx] <= cur_wdata;
    end
  end

`ifdef DMR_STATS_EN
  logic resp_hs;
  assign resp_hs = resp_valid && resp_ready;

  // Saturating transaction counters, bumped on the response handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rd  <= 16'd0;
      stat_wr  <= 16'd0;
      stat_err <= 16'd0;
    end else if (resp_hs) begin
      if (resp_we && (stat_wr != 16'hFFFF)) begin
        stat_wr <= stat_wr + 16'd1;
      end
      if (!resp_we && (stat_rd != 16'hFFFF)) begin
        stat_rd <= stat_rd + 16'd1;
      end
      if (resp_err && (stat_err != 16'hFFFF)) begin
        stat_err <= stat_err + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (WAIT 1/0/3, DEPTH 1024/512/1024)
// driven with directed and random transactions, compared each cycle against a
// transaction-level model plus literal expectations.
module tb_data_mem_responder;

  localparam int NI = 3;
  localparam int WV [NI] = '{1, 0, 3};
  localparam int DV [NI] = '{1024, 512, 1024};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [NI];
  logic        req_valid  [NI];
  logic        req_ready  [NI];
  logic        req_we     [NI];
  logic [9:0]  req_addr   [NI];
  logic [31:0] req_wdata  [NI];
  logic        resp_valid [NI];
  logic        resp_ready [NI];
  logic [31:0] resp_rdata [NI];
  logic        resp_err   [NI];
  logic        resp_we    [NI];
`ifdef DMR_STATS_EN
  logic [15:0] stat_rd  [NI];
  logic [15:0] stat_wr  [NI];
  logic [15:0] stat_err [NI];
`endif

  data_mem_responder #(.ADDR_W(10), .DATA_W(32), .DEPTH(1024), .WAIT_CYCLES(1)) u0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .resp_we(resp_we[0])
`ifdef DMR_STATS_EN
    , .stat_rd(stat_rd[0]), .stat_wr(stat_wr[0]), .stat_err(stat_err[0])
`endif
  );

  data_mem_responder #(.ADDR_W(10), .DATA_W(32), .DEPTH(512), .WAIT_CYCLES(0)) u1 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .resp_we(resp_we[1])
`ifdef DMR_STATS_EN
    , .stat_rd(stat_rd[1]), .stat_wr(stat_wr[1]), .stat_err(stat_err[1])
`endif
  );

  data_mem_responder #(.ADDR_W(10), .DATA_W(32), .DEPTH(1024), .WAIT_CYCLES(3)) u2 (
    .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]), .resp_rdata(resp_rdata[2]),
    .resp_err(resp_err[2]), .resp_we(resp_we[2])
`ifdef DMR_STATS_EN
    , .stat_rd(stat_rd[2]), .stat_wr(stat_wr[2]), .stat_err(stat_err[2])
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %h expected %h at %0t", nm, i, act, exp, $time);
  endtask

  task automatic chkb(input string nm, input int i, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %b expected %b at %0t", nm, i, act, exp, $time);
  endtask

  task automatic tmo(input string nm, input int i);
    n_chk++;
    $display("FAIL timeout %s[%0d]: got no handshake within bound, expected one", nm, i);
  endtask

  // ---------------- transaction-level reference model ----------------
  bit          m_busy  [NI];   // accepted, waiting for commit
  int          m_rem   [NI];   // edges left before commit
  bit          m_resp  [NI];   // response presented
  bit          m_we    [NI];
  logic [9:0]  m_addr  [NI];
  logic [31:0] m_wd    [NI];
  logic [31:0] e_rdata [NI];
  bit          e_err   [NI];
  bit          e_we    [NI];
  bit          e_known [NI];
  logic [31:0] mm      [NI][1024];
  bit          mw      [NI][1024];
  int          s_rd    [NI];
  int          s_wr    [NI];
  int          s_err   [NI];
  bit          started = 1'b0;

  function automatic void commit(input int i);
    bit er;
    er = (int'(m_addr[i]) >= DV[i]);
    e_err[i]   = er;
    e_we[i]    = m_we[i];
    e_rdata[i] = 32'd0;
    e_known[i] = 1'b1;
    if (m_we[i] && !er) begin
      mm[i][m_addr[i]] = m_wd[i];
      mw[i][m_addr[i]] = 1'b1;
    end else if (!m_we[i] && !er) begin
      e_rdata[i] = mm[i][m_addr[i]];
      e_known[i] = mw[i][m_addr[i]];
    end
    m_resp[i] = 1'b1;
  endfunction

  function automatic int sat(input int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < NI; i++) begin
        if (rst[i]) begin
          m_busy[i] = 0; m_rem[i] = 0; m_resp[i] = 0;
          e_rdata[i] = 0; e_err[i] = 0; e_we[i] = 0; e_known[i] = 1;
          s_rd[i] = 0; s_wr[i] = 0; s_err[i] = 0;
        end else if (m_resp[i]) begin
          if (resp_ready[i]) begin
            m_resp[i] = 0;
            if (e_we[i]) s_wr[i] = sat(s_wr[i]);
            else         s_rd[i] = sat(s_rd[i]);
            if (e_err[i]) s_err[i] = sat(s_err[i]);
          end
        end else if (m_busy[i]) begin
          m_rem[i]--;
          if (m_rem[i] == 0) begin
            m_busy[i] = 0;
            commit(i);
          end
        end else if (req_valid[i]) begin
          m_we[i] = req_we[i]; m_addr[i] = req_addr[i]; m_wd[i] = req_wdata[i];
          if (WV[i] == 0) commit(i);
          else begin
            m_busy[i] = 1;
            m_rem[i]  = WV[i];
          end
        end
      end
      started = 1'b1;
    end
  end

  // Per-cycle comparison of every instance against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        for (int i = 0; i < NI; i++) begin
          chkb("req_ready", i, req_ready[i], !(m_busy[i] || m_resp[i]));
          chkb("resp_valid", i, resp_valid[i], m_resp[i]);
          if (m_resp[i]) begin
            chkb("resp_err", i, resp_err[i], e_err[i]);
            chkb("resp_we", i, resp_we[i], e_we[i]);
            if (e_known[i]) chk("resp_rdata", i, resp_rdata[i], e_rdata[i]);
          end
`ifdef DMR_STATS_EN
          chk("stat_rd", i, 32'(stat_rd[i]), 32'(s_rd[i]));
          chk("stat_wr", i, 32'(stat_wr[i]), 32'(s_wr[i]));
          chk("stat_err", i, 32'(stat_err[i]), 32'(s_err[i]));
`endif
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic issue(input int i, input bit we, input logic [9:0] a, input logic [31:0] d);
    bit acc;
    int n;
    req_valid[i] = 1'b1; req_we[i] = we; req_addr[i] = a; req_wdata[i] = d;
    acc = 0; n = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = (req_ready[i] === 1'b1);
      @(posedge clk); #1;
      n++;
    end
    if (!acc) tmo("accept", i);
    req_valid[i] = 1'b0;
    req_we[i]    = 1'($urandom_range(0, 1));
    req_addr[i]  = 10'($urandom);
    req_wdata[i] = $urandom;
  endtask

  task automatic collect(input int i, input bit rnd, output logic [31:0] rd,
                         output bit er, output bit rwe, output int lat);
    bit hs;
    int n;
    rd = 0; er = 0; rwe = 0; lat = -1; hs = 0; n = 0;
    while (!hs && n < 100) begin
      resp_ready[i] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (resp_valid[i] && lat < 0) lat = n;
      if (resp_valid[i] && resp_ready[i]) begin
        hs = 1; rd = resp_rdata[i]; er = resp_err[i]; rwe = resp_we[i];
      end
      @(posedge clk); #1;
      n++;
    end
    resp_ready[i] = 1'b0;
    if (!hs) tmo("response", i);
  endtask

  logic [31:0] g_rd;
  bit          g_er, g_we;
  int          g_lat;

  task automatic txn(input int i, input bit we, input logic [9:0] a, input logic [31:0] d, input bit rnd);
    issue(i, we, a, d);
    collect(i, rnd, g_rd, g_er, g_we, g_lat);
  endtask

  initial begin
    bit seen;
`ifdef DMR_STATS_EN
    int b_rd, b_wr, b_err;
`endif
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1; req_valid[i] = 0; req_we[i] = 0; req_addr[i] = 0;
      req_wdata[i] = 0; resp_ready[i] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chkb("rst_req_ready", i, req_ready[i], 1'b1);
      chkb("rst_resp_valid", i, resp_valid[i], 1'b0);
      chk("rst_rdata", i, resp_rdata[i], 32'd0);
      chkb("rst_err", i, resp_err[i], 1'b0);
      chkb("rst_we", i, resp_we[i], 1'b0);
    end
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) rst[i] = 0;

    // WAIT_CYCLES=1: store then load at address 5.
    txn(0, 1, 10'd5, 32'hDEADBEEF, 0);
    chk("st5_lat", 0, 32'(g_lat), 32'd1);
    chkb("st5_we", 0, g_we, 1'b1);
    chkb("st5_err", 0, g_er, 1'b0);
    chk("st5_rdata", 0, g_rd, 32'd0);
    txn(0, 0, 10'd5, 32'd0, 0);
    chk("ld5_rdata", 0, g_rd, 32'hDEADBEEF);

    // Response held off for 5 cycles while a new request waits.
    issue(0, 0, 10'd5, 32'd0);
    req_valid[0] = 1; req_we[0] = 1; req_addr[0] = 10'd9; req_wdata[0] = 32'h99;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = resp_valid[0];
    end
    if (!seen) tmo("hold_resp", 0);
    repeat (5) @(negedge clk);
    chkb("hold_valid", 0, resp_valid[0], 1'b1);
    chk("hold_rdata", 0, resp_rdata[0], 32'hDEADBEEF);
    chkb("hold_req_ready", 0, req_ready[0], 1'b0);
    @(posedge clk); #1;
    collect(0, 0, g_rd, g_er, g_we, g_lat);
    chk("hold_ld_rdata", 0, g_rd, 32'hDEADBEEF);
    issue(0, 1, 10'd9, 32'h99);
    collect(0, 0, g_rd, g_er, g_we, g_lat);
    txn(0, 0, 10'd9, 32'd0, 0);
    chk("ld9_rdata", 0, g_rd, 32'h99);

    // WAIT_CYCLES=0, DEPTH=512: latency and out-of-range accesses.
    txn(1, 1, 10'd5, 32'h0BADF00D, 0);
    txn(1, 0, 10'd5, 32'd0, 0);
    chk("w0_lat", 1, 32'(g_lat), 32'd0);
    chk("w0_rdata", 1, g_rd, 32'h0BADF00D);
    txn(1, 1, 10'd88, 32'h5555, 0);
    txn(1, 1, 10'd600, 32'h1234, 0);
    chkb("st600_err", 1, g_er, 1'b1);
    chkb("st600_we", 1, g_we, 1'b1);
    txn(1, 0, 10'd600, 32'd0, 0);
    chkb("ld600_err", 1, g_er, 1'b1);
    chk("ld600_rdata", 1, g_rd, 32'd0);
    txn(1, 0, 10'd88, 32'd0, 0);
    chk("alias88_rdata", 1, g_rd, 32'h5555);

`ifdef DMR_STATS_EN
    b_rd = int'(stat_rd[1]); b_wr = int'(stat_wr[1]); b_err = int'(stat_err[1]);
    txn(1, 0, 10'd5, 32'd0, 0);
    txn(1, 0, 10'd88, 32'd0, 0);
    txn(1, 0, 10'd5, 32'd0, 0);
    txn(1, 1, 10'd1, 32'h1, 0);
    txn(1, 1, 10'd2, 32'h2, 0);
    txn(1, 0, 10'd700, 32'd0, 0);
    chk("stat_rd_delta", 1, 32'(int'(stat_rd[1]) - b_rd), 32'd4);
    chk("stat_wr_delta", 1, 32'(int'(stat_wr[1]) - b_wr), 32'd2);
    chk("stat_err_delta", 1, 32'(int'(stat_err[1]) - b_err), 32'd1);
`endif

    // WAIT_CYCLES=3: reset while a store is still waiting.
    txn(2, 1, 10'd7, 32'h11, 0);
    chk("w3_lat", 2, 32'(g_lat), 32'd3);
    issue(2, 1, 10'd7, 32'hAA);
    rst[2] = 1;
    @(posedge clk); #1;
    rst[2] = 0;
    @(negedge clk);
    chkb("rst_mid_ready", 2, req_ready[2], 1'b1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid[2]) seen = 1;
    end
    chkb("rst_mid_no_resp", 2, seen, 1'b0);
    @(posedge clk); #1;
    txn(2, 0, 10'd7, 32'd0, 0);
    chk("rst_mid_ld7", 2, g_rd, 32'h11);

    // Random traffic with random response backpressure.
    for (int i = 0; i < NI; i++) begin
      for (int t = 0; t < 60; t++) begin
        logic [9:0] a;
        a = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 15));
        txn(i, 1'($urandom_range(0, 1)), a, $urandom, 1);
      end
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
